rom_bank_mapper: RTL and testbench

//  Parametrised cartridge ROM bank mapper plus request bridge between the console ROM port and the DDR ROM reader.

---
 rtl/rom_bank_mapper_if.sv | 22 ++
 rtl/rom_bank_mapper.sv | 141 ++++++++++++++
 tb/tb_rom_bank_mapper.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_bank_mapper_if.sv
// rom_bank_mapper_if
//   Toggle-handshake read bus used on both sides of the ROM bank mapper.
//   A request is outstanding while req != ack; the responder makes
//   ack equal to req once rdata is valid.
// Parameters
//   AW     top bit of the word address (address is [AW:1], byte bit 0 implied)
// Signals
//   addr   word address, held stable by the master while a request is outstanding
//   req    request toggle, driven by the master
//   ack    acknowledge toggle, driven by the slave
//   rdata  16-bit read data, valid when ack == req
interface rom_bank_mapper_if #(
  parameter int AW = 22
);
  logic [AW:1] addr;
  logic        req;
  logic        ack;
  logic [15:0] rdata;

  modport master (output addr, output req, input ack, input rdata);
  modport slave  (input addr, input req, output ack, output rdata);
endinterface

// File: rtl/rom_bank_mapper.sv
// rom_bank_mapper
//   Cartridge ROM bank mapper and request bridge between the console ROM
//   port and the DDR ROM reader. BANKS page registers, written through the
//   mapper register port, translate CPU word addresses into physical ROM
//   word addresses. Pages are wrapped by rom_mask, writes can be locked out
//   during ROM download, and a reset during an outstanding memory read
//   drains the memory response instead of delivering it.
// Ports
//   clk_sys   system clock
//   reset     synchronous, active-high
//   lock      1: page-register writes ignored
//   map_we    one-cycle page-register write strobe
//   map_a     slot index for write / readback
//   map_d     page number to write
//   map_q     combinational readback of the page register at map_a
//   rom_mask  page mask applied at translation
//   use_map   1 once any page-register write has been accepted since reset
//   cpu       console side of the bridge (this block is the slave)
//   mem       memory side of the bridge (this block is the master)
module rom_bank_mapper #(
  parameter int BANKS     = 8,
  parameter int BANK_AW   = 19,
  parameter int PAGE_W    = 6,
  parameter int CPU_AW    = 22,
  parameter bit FIX_SLOT0 = 1'b1,
  localparam int SW       = $clog2(BANKS),
  localparam int MEM_AW   = PAGE_W + BANK_AW - 1
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               lock,
  input  logic               map_we,
  input  logic [SW-1:0]      map_a,
  input  logic [PAGE_W-1:0]  map_d,
  output logic [PAGE_W-1:0]  map_q,
  input  logic [PAGE_W-1:0]  rom_mask,
  output logic               use_map,
  rom_bank_mapper_if.slave   cpu,
  rom_bank_mapper_if.master  mem
);

  typedef logic [BANKS-1:0][PAGE_W-1:0] map_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic map_t identity_map();
    map_t m;
    for (int unsigned i = 0; i < BANKS; i++) begin
      m[i] = PAGE_W'(i);
    end
    return m;
  endfunction

  // Power-up values: bridge idle with both toggles at 0, identity mapping.
  map_t             map_r      = identity_map();
  logic             use_map_r  = 1'b0;
  state_t           state      = IDLE;
  logic             mem_req_r  = 1'b0;
  logic [MEM_AW:1]  mem_addr_r = '0;
  logic             cpu_ack_r  = 1'b0;
  logic [15:0]      cpu_dout_r = '0;

  logic             map_wr;
  logic [SW-1:0]    slot;
  logic [MEM_AW:1]  xlat;

  // Page-register port

  assign map_wr = map_we & ~lock & ~(FIX_SLOT0 && (map_a == '0));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      map_r     <= identity_map();
      use_map_r <= 1'b0;
    end else if (map_wr) begin
      map_r[map_a] <= map_d;
      use_map_r    <= 1'b1;
    end
  end

  assign map_q   = map_r[map_a];
  assign use_map = use_map_r;

  // Address translation, sampled into mem_addr only when a request issues,
  // so later map or mask changes never disturb an outstanding read.

  always_comb begin
    slot = cpu.addr[BANK_AW+SW-1:BANK_AW];
    if (use_map_r) begin
      xlat = {map_r[slot] & rom_mask, cpu.addr[BANK_AW-1:1]};
    end else begin
      xlat = MEM_AW'(cpu.addr[CPU_AW:1]);
    end
  end

  // Request bridge

  // On reset the CPU side is squared up immediately (pending request dropped),
  // but the memory toggle is left alone: a read already in flight is tracked
  // in DRAIN until its ack arrives so the toggle pair stays in step.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cpu_ack_r  <= cpu.req;
      cpu_dout_r <= '0;
      state      <= (state == IDLE) ? IDLE : DRAIN;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu.req != cpu_ack_r) begin
            mem_addr_r <= xlat;
            mem_req_r  <= ~mem_req_r;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (mem.ack == mem_req_r) begin
            cpu_dout_r <= mem.rdata;
            cpu_ack_r  <= ~cpu_ack_r;
            state      <= IDLE;
          end
        end
        DRAIN: begin
          if (mem.ack == mem_req_r) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu.ack   = cpu_ack_r;
  assign cpu.rdata = cpu_dout_r;
  assign mem.req   = mem_req_r;
  assign mem.addr  = mem_addr_r;

endmodule

// File: tb/tb_rom_bank_mapper.sv
// tb_rom_bank_mapper
//   Self-checking bench for rom_bank_mapper with default parameters.
//   A behavioural model holds the page table as an integer array and
//   computes physical addresses with byte-address arithmetic; a memory
//   model answers toggle requests after a programmable latency with data
//   derived from the address it was given.
module tb_rom_bank_mapper;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        lock;
  logic        map_we;
  logic [2:0]  map_a;
  logic [5:0]  map_d;
  logic [5:0]  map_q;
  logic [5:0]  rom_mask;
  logic        use_map;

  rom_bank_mapper_if #(.AW(22)) cpu ();
  rom_bank_mapper_if #(.AW(24)) mem ();

  rom_bank_mapper #(
    .BANKS    (8),
    .BANK_AW  (19),
    .PAGE_W   (6),
    .CPU_AW   (22),
    .FIX_SLOT0(1'b1)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .lock    (lock),
    .map_we  (map_we),
    .map_a   (map_a),
    .map_d   (map_d),
    .map_q   (map_q),
    .rom_mask(rom_mask),
    .use_map (use_map),
    .cpu     (cpu),
    .mem     (mem)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;

  // Reference model
  int unsigned model_map [8];
  bit          model_use;
  logic [2:0]  pend_a;
  logic [5:0]  pend_d;

  function automatic void reset_model();
    for (int i = 0; i < 8; i++) model_map[i] = i;
    model_use = 1'b0;
  endfunction

  // Expected physical word address from the CPU word address.
  function automatic logic [23:0] exp_word(input logic [21:0] wa, input logic [5:0] mask);
    int unsigned b, slot, off, page;
    if (!model_use) return {2'b00, wa};
    b    = 32'(wa) * 2;
    slot = (b / 524288) % 8;
    off  = b % 524288;
    page = model_map[slot] & 32'(mask);
    return 24'((page * 524288 + off) / 2);
  endfunction

  function automatic logic [15:0] data_fn(input logic [23:0] a);
    return a[15:0] ^ {8'h5A, a[23:16]};
  endfunction

  // Memory model
  int mem_lat = 0;
  int lat_cnt = 0;

  initial begin
    mem.ack   = 1'b0;
    mem.rdata = '0;
    forever begin
      @(negedge clk_sys);
      if (mem.req !== mem.ack) begin
        if (lat_cnt >= mem_lat) begin
          mem.rdata = data_fn(mem.addr);
          mem.ack   = mem.req;
          lat_cnt   = 0;
        end else begin
          lat_cnt++;
        end
      end
    end
  end

  // Stimulus helpers (all start and end 1ns after a rising edge)
  task automatic start_write(input logic [2:0] a, input logic [5:0] d);
    map_we = 1'b1; map_a = a; map_d = d;
    pend_a = a;    pend_d = d;
  endtask

  task automatic end_write();
    map_we = 1'b0;
    if (!lock && pend_a != 3'd0) begin
      model_map[pend_a] = pend_d;
      model_use = 1'b1;
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [5:0] d);
    start_write(a, d);
    @(posedge clk_sys); #1;
    end_write();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    reset_model();
  endtask

  // wr_mode 0: plain read; 1: map write in the issue cycle; 2: map write while waiting
  task automatic do_read(input logic [21:0] wa, input int wr_mode,
                         input logic [2:0] wslot, input logic [5:0] wdata, input string tag);
    logic [23:0] exp_a;
    logic        prev_mreq;
    int          n;
    exp_a     = exp_word(wa, rom_mask);
    prev_mreq = mem.req;
    cpu.addr  = wa;
    cpu.req   = ~cpu.req;
    if (wr_mode == 1) start_write(wslot, wdata);
    @(posedge clk_sys); #1;
    if (wr_mode == 1) end_write();
    checks++;
    if (mem.req === prev_mreq) begin
      errors++; $display("FAIL %s issue: mem_req=%b want %b", tag, mem.req, ~prev_mreq);
    end
    checks++;
    if (mem.addr !== exp_a) begin
      errors++; $display("FAIL %s addr: mem_addr=%h want %h", tag, mem.addr, exp_a);
    end
    if (wr_mode == 2) start_write(wslot, wdata);
    n = 1;
    while (cpu.ack !== cpu.req && n < 60) begin
      @(posedge clk_sys); #1;
      n++;
      if (map_we) end_write();
    end
    checks++;
    if (cpu.ack !== cpu.req) begin
      errors++; $display("FAIL %s ack timeout: cpu_ack=%b want %b", tag, cpu.ack, cpu.req);
    end else if (n != mem_lat + 2) begin
      errors++; $display("FAIL %s latency: cycles=%0d want %0d", tag, n, mem_lat + 2);
    end
    checks++;
    if (cpu.rdata !== data_fn(exp_a)) begin
      errors++; $display("FAIL %s data: cpu_dout=%h want %h", tag, cpu.rdata, data_fn(exp_a));
    end
    if (wr_mode == 2) begin
      checks++;
      if (mem.addr !== exp_a) begin
        errors++; $display("FAIL %s held addr: mem_addr=%h want %h", tag, mem.addr, exp_a);
      end
    end
  endtask

  task automatic check_map(input logic [2:0] a, input string tag);
    map_a = a; #1;
    checks++;
    if (map_q !== 6'(model_map[a])) begin
      errors++; $display("FAIL %s map_q[%0d]: got %h want %h", tag, a, map_q, 6'(model_map[a]));
    end
  endtask

  task automatic check_use(input string tag);
    checks++;
    if (use_map !== model_use) begin
      errors++; $display("FAIL %s use_map: got %b want %b", tag, use_map, model_use);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    reset = 1'b1; lock = 1'b0; map_we = 1'b0; map_a = '0; map_d = '0;
    rom_mask = 6'h3F; cpu.addr = '0; cpu.req = 1'b0; mem_lat = 0;
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    reset_model();
    check_use("reset");
    checks++;
    if (cpu.ack !== cpu.req || cpu.rdata !== 16'h0000) begin
      errors++; $display("FAIL reset bridge: ack=%b dout=%h want ack=%b dout=0000", cpu.ack, cpu.rdata, cpu.req);
    end
    for (int i = 0; i < 8; i++) check_map(3'(i), "reset");
  endtask

  task automatic test_identity();
    do_read(22'h05_0000, 0, 3'd0, 6'd0, "identity");
    check_use("identity");
  endtask

  task automatic test_mapped();
    do_write(3'd5, 6'h0C);
    check_use("mapped");
    rom_mask = 6'h3F;
    do_read(22'h16_091A, 0, 3'd0, 6'd0, "mapped");
  endtask

  task automatic test_slot0_lock();
    pulse_reset();
    do_write(3'd0, 6'd7);
    check_map(3'd0, "slot0");
    check_use("slot0");
    lock = 1'b1;
    do_write(3'd3, 6'd9);
    check_map(3'd3, "lock");
    check_use("lock");
    lock = 1'b0;
  endtask

  task automatic test_mask_wrap();
    do_write(3'd7, 6'h3F);
    rom_mask = 6'h0F;
    do_read(22'h1C_0001, 0, 3'd0, 6'd0, "wrap");
    rom_mask = 6'h3F;
  endtask

  task automatic test_same_cycle_write();
    do_read(22'h08_0000, 1, 3'd2, 6'h20, "same_cycle");
    check_map(3'd2, "same_cycle");
    do_read(22'h08_0000, 0, 3'd0, 6'd0, "after_write");
  endtask

  task automatic test_write_in_wait();
    logic [21:0] wa;
    mem_lat = 3;
    wa = 22'($urandom);
    do_read(wa, 2, 3'(wa[21:19]), 6'($urandom), "in_wait");
    mem_lat = 0;
    do_read(wa, 0, 3'd0, 6'd0, "reread");
  endtask

  task automatic test_reset_in_wait();
    logic prev_mreq;
    int   n;
    mem_lat   = 5;
    prev_mreq = mem.req;
    cpu.addr  = 22'($urandom);
    cpu.req   = ~cpu.req;
    @(posedge clk_sys); #1;
    checks++;
    if (mem.req === prev_mreq) begin
      errors++; $display("FAIL rst_wait issue: mem_req=%b want %b", mem.req, ~prev_mreq);
    end
    pulse_reset();
    check_use("rst_wait");
    n = 0;
    while (mem.ack !== mem.req && n < 20) begin
      checks++;
      if (cpu.ack !== cpu.req || cpu.rdata !== 16'h0000) begin
        errors++; $display("FAIL rst_wait drain: ack=%b dout=%h want ack=%b dout=0000", cpu.ack, cpu.rdata, cpu.req);
      end
      @(posedge clk_sys); #1;
      n++;
    end
    checks++;
    if (mem.ack !== mem.req) begin
      errors++; $display("FAIL rst_wait mem timeout: mem_ack=%b want %b", mem.ack, mem.req);
    end
    checks++;
    if (cpu.ack !== cpu.req || cpu.rdata !== 16'h0000) begin
      errors++; $display("FAIL rst_wait discard: ack=%b dout=%h want ack=%b dout=0000", cpu.ack, cpu.rdata, cpu.req);
    end
    mem_lat = 1;
    do_read(22'($urandom), 0, 3'd0, 6'd0, "post_reset");
  endtask

  task automatic test_random();
    logic [5:0] masks [4];
    masks = '{6'h3F, 6'h1F, 6'h0F, 6'h07};
    for (int i = 0; i < 60; i++) begin
      lock = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        do_write(3'($urandom_range(0, 7)), 6'($urandom));
        check_map(3'($urandom_range(0, 7)), "rand");
      end
      rom_mask = masks[$urandom_range(0, 3)];
      mem_lat  = $urandom_range(0, 3);
      do_read(22'($urandom), $urandom_range(0, 2), 3'($urandom_range(0, 7)), 6'($urandom), "rand");
      check_use("rand");
    end
    lock = 1'b0;
  endtask

  task automatic test_back_to_back();
    mem_lat  = 0;
    rom_mask = 6'h3F;
    for (int i = 0; i < 8; i++) do_read(22'($urandom), 0, 3'd0, 6'd0, "b2b");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_identity();
    test_mapped();
    test_slot0_lock();
    test_mask_wrap();
    test_same_cycle_write();
    test_write_in_wait();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
